// File: rtl/ad_pkg.sv
// ---------------------------------------------------------------------------
// ad_pkg
// Shared definitions for the dpram read-stream controller: the FSM state
// encoding and a clog2 helper used to size FIFO pointers and counters.
// ---------------------------------------------------------------------------
package ad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Bits needed to index 'value' distinct items (clog2(1) = 0).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ad_sync_fifo.sv
// ---------------------------------------------------------------------------
// ad_sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on o_pop_data
// whenever o_empty is low; i_pop consumes it on the next edge.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active-high (clears pointers and count)
//   i_push       write i_push_data (ignored when full)
//   i_push_data  write data
//   i_pop        consume head entry (ignored when empty)
//   o_pop_data   head entry
//   o_empty      no entries stored
//   o_full       DEPTH entries stored
//   o_count      number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ad_sync_fifo
   import ad_pkg::*;
#(
   parameter  int WIDTH = 34,
   parameter  int DEPTH = 8,
   localparam int PW    = clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_empty,
   output logic             o_full,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      o_empty    = (count_q == '0);
      o_full     = (count_q == CW'(DEPTH));
      o_count    = count_q;
      o_pop_data = mem_q[rd_ptr_q];
      push_ok    = i_push && !o_full;
      pop_ok     = i_pop && !o_empty;

      // DEPTH is a power of two, so pointers wrap by natural overflow.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the empty flag guards every read of it.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
   end

endmodule

// File: rtl/ad_dpram_rd_stream.sv
// ---------------------------------------------------------------------------
// ad_dpram_rd_stream
// Read-side controller for the dual-port block RAM. A start command sweeps
// a contiguous (wrapping) address range over the RAM read port, absorbs the
// fixed read latency and presents the words as a valid/ready stream.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for i_start with a non-zero i_len
//   ST_ISSUE | issuing reads while credit allows; last issue -> ST_DRAIN
//   ST_DRAIN | all reads issued; waiting for the o_m_last beat to handshake
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start, i_base_addr,
//   i_len                  command (len 1..2^ADDR_WIDTH, 0 is ignored)
//   o_busy, o_done         command in progress / one-cycle completion pulse
//   o_rd_en, o_rd_addr,
//   i_rd_data              dpram read port (RD_LATENCY cycles en -> data)
//   o_m_data, o_m_valid,
//   o_m_last, i_m_ready    output stream
// ---------------------------------------------------------------------------
module ad_dpram_rd_stream
   import ad_pkg::*;
#(
   parameter int BRAM_WIDTH = 33,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH:0]   i_len,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic [BRAM_WIDTH-1:0] i_rd_data,
   output logic [BRAM_WIDTH-1:0] o_m_data,
   output logic                  o_m_valid,
   output logic                  o_m_last,
   input  logic                  i_m_ready
);

   localparam int LW = ADDR_WIDTH + 1;
   localparam int IW = clog2(RD_LATENCY + 1);
   localparam int CW = clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;
   localparam int FW = BRAM_WIDTH + 1;

   if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
      $error("ad_dpram_rd_stream: FIFO_DEPTH must be >= RD_LATENCY+2");
   end
   if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_pow2
      $error("ad_dpram_rd_stream: FIFO_DEPTH must be a power of two");
   end

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LW-1:0]           remaining_q, remaining_d;
   logic [IW-1:0]           inflight_q, inflight_d;
   logic [RD_LATENCY-1:0]   pipe_valid_q, pipe_valid_d;
   logic [RD_LATENCY-1:0]   pipe_last_q, pipe_last_d;
   logic                    done_q, done_d;

   logic                    rd_en;
   logic                    capture;
   logic                    pop;
   logic [SW-1:0]           credit_used;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic [CW-1:0]           fifo_count;
   logic [FW-1:0]           fifo_dout;

   // Credit: every issued read owns a FIFO slot from issue until it is
   // popped, so the FIFO cannot overflow however long the sink stalls.
   // Only registered state feeds rd_en; i_m_ready acts one cycle later.
   always_comb begin
      credit_used = SW'(inflight_q) + SW'(fifo_count);
      rd_en       = (state_q == ST_ISSUE) && !fifo_full &&
                    (credit_used < SW'(FIFO_DEPTH));
      capture     = pipe_valid_q[RD_LATENCY-1];
      pop         = !fifo_empty && i_m_ready;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start && (i_len != '0)) begin
               state_d     = ST_ISSUE;
               addr_d      = i_base_addr;
               remaining_d = i_len;
            end
         end
         ST_ISSUE: begin
            if (rd_en) begin
               addr_d      = addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - LW'(1);
               if (remaining_q == LW'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && fifo_dout[FW-1]) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Latency tracker: one {valid,last} slot per RAM pipeline stage, so the
   // tail lines up with i_rd_data for the read issued RD_LATENCY cycles ago.
   always_comb begin
      pipe_valid_d    = '0;
      pipe_last_d     = '0;
      pipe_valid_d[0] = rd_en;
      pipe_last_d[0]  = rd_en && (remaining_q == LW'(1));
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
         pipe_last_d[i]  = pipe_last_q[i-1];
      end
      case ({rd_en, capture})
         2'b10:   inflight_d = inflight_q + IW'(1);
         2'b01:   inflight_d = inflight_q - IW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         inflight_q   <= '0;
         pipe_valid_q <= '0;
         pipe_last_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         inflight_q   <= inflight_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_last_q  <= pipe_last_d;
         done_q       <= done_d;
      end
   end

   ad_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (capture),
      .i_push_data ({pipe_last_q[RD_LATENCY-1], i_rd_data}),
      .i_pop       (pop),
      .o_pop_data  (fifo_dout),
      .o_empty     (fifo_empty),
      .o_full      (fifo_full),
      .o_count     (fifo_count)
   );

   // FIFO storage is unreset, so stream data/last are forced to zero while
   // empty; this gives clean reset values and is stable while stalled.
   always_comb begin
      o_busy    = (state_q != ST_IDLE);
      o_done    = done_q;
      o_rd_en   = rd_en;
      o_rd_addr = addr_q;
      o_m_valid = !fifo_empty;
      o_m_last  = !fifo_empty && fifo_dout[FW-1];
      o_m_data  = fifo_empty ? '0 : fifo_dout[BRAM_WIDTH-1:0];
   end

endmodule

// File: tb/tb_ad_dpram_rd_stream.sv
module tb_ad_dpram_rd_stream;
   localparam int BW  = 33;
   localparam int AW  = 8;
   localparam int LAT = 3;
   localparam int FD  = 8;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_start;
   logic [AW-1:0] i_base_addr;
   logic [AW:0]   i_len;
   logic          o_busy, o_done, o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic [BW-1:0] i_rd_data;
   logic [BW-1:0] o_m_data;
   logic          o_m_valid, o_m_last;
   logic          i_m_ready;

   always #5 i_clk = ~i_clk;

   ad_dpram_rd_stream #(
      .BRAM_WIDTH (BW),
      .ADDR_WIDTH (AW),
      .RD_LATENCY (LAT),
      .FIFO_DEPTH (FD)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_len       (i_len),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_rd_en     (o_rd_en),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (i_rd_data),
      .o_m_data    (o_m_data),
      .o_m_valid   (o_m_valid),
      .o_m_last    (o_m_last),
      .i_m_ready   (i_m_ready)
   );

   // dpram read-port model: mem[k] = k + 0x100, 3-cycle latency.
   logic [BW-1:0] mem [256];
   logic [BW-1:0] s1, s2, s3;
   initial for (int k = 0; k < 256; k++) mem[k] = BW'(k + 256);
   always @(posedge i_clk) begin
      s1 <= o_rd_en ? mem[o_rd_addr] : 33'h1_DEAD_BEEF;
      s2 <= s1;
      s3 <= s2;
   end
   assign i_rd_data = s3;

   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   int            start_cyc = 0;
   logic [BW:0]   sb [$];
   int            out_cnt = 0;
   int            total_issued = 0;
   int            total_popped = 0;
   logic          prev_stall = 1'b0;
   logic [BW-1:0] prev_data;
   logic          prev_last;
   logic          tb_busy = 1'b0;
   int            ready_mode = 0;
   int            stretch_left = 0;
   logic          cur_ready = 1'b1;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW:0] exp_word(input logic [AW-1:0] base, input int i, input int len);
      logic [AW-1:0] a;
      a = base + AW'(i);
      return {(i == len - 1), BW'(a) + BW'(256)};
   endfunction

   // Scoreboard consumer, stall-stability and credit checks.
   always @(negedge i_clk) begin
      logic [BW:0] e;
      if (i_rst) begin
         out_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(o_m_valid), 64'd1);
            check("hold_data", 64'(o_m_data), 64'(prev_data));
            check("hold_last", 64'(o_m_last), 64'(prev_last));
         end
         if (o_m_valid && i_m_ready) begin
            check("beat_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("beat_data", 64'(o_m_data), 64'(e[BW-1:0]));
               check("beat_last", 64'(o_m_last), 64'(e[BW]));
            end
            total_popped++;
            out_cnt--;
         end
         if (o_rd_en) begin
            total_issued++;
            out_cnt++;
            check("credit_le_depth", 64'(out_cnt <= FD), 64'd1);
         end
         prev_stall = o_m_valid && !i_m_ready;
         prev_data  = o_m_data;
         prev_last  = o_m_last;
      end
   end

   task automatic issue_start(input logic [AW-1:0] base, input logic [AW:0] len);
      bit accept;
      accept = (len != '0) && !tb_busy;
      if (accept)
         for (int i = 0; i < int'(len); i++) sb.push_back(exp_word(base, i, int'(len)));
      i_base_addr = base;
      i_len       = len;
      i_start     = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      if (accept) begin
         tb_busy   = 1'b1;
         start_cyc = cyc - 1;
      end
   endtask

   task automatic set_ready();
      if (ready_mode == 0) begin
         i_m_ready = 1'b1;
      end else begin
         if (stretch_left == 0) begin
            cur_ready    = ~cur_ready;
            stretch_left = cur_ready ? int'($urandom_range(1, 4)) : int'($urandom_range(10, 14));
         end
         stretch_left--;
         i_m_ready = cur_ready;
      end
   endtask

   task automatic wait_done(input int budget, output int done_at);
      bit got;
      got     = 1'b0;
      done_at = -1;
      for (int c = 0; c < budget && !got; c++) begin
         set_ready();
         @(negedge i_clk);
         if (o_done) begin
            got     = 1'b1;
            done_at = cyc - start_cyc;
         end else begin
            @(posedge i_clk);
            #1;
         end
      end
      check("done_seen", 64'(got), 64'd1);
      check("sb_drained", 64'(sb.size()), 64'd0);
      tb_busy = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(o_busy), 64'd0);
      check({tag, "_done"}, 64'(o_done), 64'd0);
      check({tag, "_rd_en"}, 64'(o_rd_en), 64'd0);
      check({tag, "_rd_addr"}, 64'(o_rd_addr), 64'd0);
      check({tag, "_valid"}, 64'(o_m_valid), 64'd0);
      check({tag, "_last"}, 64'(o_m_last), 64'd0);
      check({tag, "_data"}, 64'(o_m_data), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, n0, p0;
      i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_m_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_reset_outputs("reset");
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      // Basic read: cycle-exact timing, data through the scoreboard.
      issue_start(8'h10, 9'd4);
      for (int c = 1; c <= 9; c++) begin
         @(negedge i_clk);
         check($sformatf("basic_rd_en_c%0d", c), 64'(o_rd_en), 64'(c <= 4));
         if (c <= 4) check($sformatf("basic_addr_c%0d", c), 64'(o_rd_addr), 64'(8'h10 + c - 1));
         check($sformatf("basic_valid_c%0d", c), 64'(o_m_valid), 64'(c >= 5 && c <= 8));
         check($sformatf("basic_last_c%0d", c), 64'(o_m_last), 64'(c == 8));
         check($sformatf("basic_busy_c%0d", c), 64'(o_busy), 64'(c <= 8));
         check($sformatf("basic_done_c%0d", c), 64'(o_done), 64'(c == 9));
      end
      tb_busy = 1'b0;
      check("basic_sb_drained", 64'(sb.size()), 64'd0);

      // Wrap-around, started in the same cycle o_done is high.
      issue_start(8'hFE, 9'd4);
      wait_done(40, d);
      check("wrap_done_cycle", 64'(d), 64'd9);

      // len=0 in IDLE is ignored.
      n0 = total_issued;
      issue_start(8'h10, 9'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         check("len0_busy", 64'(o_busy), 64'd0);
         check("len0_rd_en", 64'(o_rd_en), 64'd0);
      end
      check("len0_issued", 64'(total_issued - n0), 64'd0);

      // Start while busy is ignored.
      n0 = total_issued;
      issue_start(8'h40, 9'd8);
      i_base_addr = 8'h80; i_len = 9'd5; i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      wait_done(60, d);
      check("busy_start_done_cycle", 64'(d), 64'd13);
      check("busy_start_issued", 64'(total_issued - n0), 64'd8);

      // Backpressure with long ready-low stretches.
      ready_mode = 1; cur_ready = 1'b1; stretch_left = 0;
      issue_start(8'h30, 9'd20);
      wait_done(2000, d);
      ready_mode = 0;
      i_m_ready  = 1'b1;

      // Full sweep at full throughput.
      issue_start(8'h00, 9'd256);
      wait_done(400, d);
      check("sweep_done_cycle", 64'(d), 64'd261);

      // Mid-transfer reset during beat 3 (fourth beat, cycle 8).
      p0 = total_popped;
      issue_start(8'h20, 9'd10);
      repeat (7) begin
         @(posedge i_clk);
         #1;
      end
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      sb.delete();
      tb_busy = 1'b0;
      @(negedge i_clk);
      check_reset_outputs("midrst");
      check("midrst_beats_before", 64'(total_popped - p0), 64'd3);
      for (int c = 0; c < 8; c++) begin
         @(negedge i_clk);
         check("midrst_no_stale_valid", 64'(o_m_valid), 64'd0);
         check("midrst_no_rd_en", 64'(o_rd_en), 64'd0);
      end
      issue_start(8'h50, 9'd3);
      wait_done(40, d);
      check("post_rst_done_cycle", 64'(d), 64'd8);

      @(posedge i_clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
